id_stage: RTL and testbench
===========================

// Module: id_stage
// PURPOSE
//  Instruction-decode stage of the 5-stage RV32I pipeline; consumes instruction/next_pc from IF.
//  Holds the 32x32 register file and decodes the RV32I subset into control bits and an immediate.
//  Detects load-use hazards and drives the ID/EX pipeline register consumed by EX.
// PARAMETERS
//  DATA_W      32  datapath / register width
//  REG_ADDR_W  5   register index width (2**REG_ADDR_W registers, x0 hardwired zero)
// PORTS
//  clk            in   1       rising-edge clock
//  reset          in   1       synchronous, active-high reset
//  instruction    in   32      instruction from IF (already registered there)
//  next_pc        in   32      PC+4 of that instruction, from IF
//  flush          in   1       branch/jump redirect resolved in EX; kill the instruction in ID
//  wb_we          in   1       write-back enable
//  wb_rd          in   5       write-back destination
//  wb_data        in   DATA_W  write-back data
//  pc_stall       out  1       combinational; hold PC (IF re-fetches the same instruction)
//  ex_valid       out  1       ID/EX holds a real instruction
//  ex_pc_plus4    out  32      registered next_pc
//  ex_rs1_data    out  DATA_W  operand A;  ex_rs2_data out DATA_W operand B
//  ex_imm         out  32      sign-extended immediate
//  ex_rs1, ex_rs2, ex_rd  out 5 register indices (0 when unused)
//  ex_alu_op      out  4       ALU opcode (pkg enum)
//  ex_alu_src     out  1       1 = imm as operand B
//  ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch, ex_jump  out 1 each
//  ex_illegal     out  1       undecodable nonzero opcode reached ID/EX
// BEHAVIOUR
//  - Reset: every ex_* output 0 on the next edge; pc_stall 0; register file is NOT cleared.
//  - Latency: instruction present in cycle n -> decoded fields on ex_* after edge n+1.
//  - Decoded subset: R-type ALU, I-type ALU, LW, SW, BEQ/BNE, JAL, JALR, LUI. Unused rs fields -> 0.
//  - instruction==0 is a bubble: ex_valid=0, all controls 0, ex_illegal=0.
//  - Other undecodable opcodes: ex_valid=1, ex_illegal=1, all write/mem controls 0.
//  - Load-use: ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==rs1 or ex_rd==rs2, used fields only)
//    -> pc_stall=1, next ID/EX is a bubble; the same instruction is decoded again next cycle.
//  - flush=1: next ID/EX is a bubble; overrides load-use (pc_stall forced 0).
//  - Reg file: two async read ports, one sync write port; writes to x0 ignored; x0 reads 0.
//  - Precedence per edge: reset > flush > load-use bubble > normal decode.
// CONFIGURATION
//  ID_WB_BYPASS_EN defined: a read of the register being written this cycle (wb_we, wb_rd!=0)
//    returns wb_data (write-through).
//  Not defined: the read returns the old value; WB must write in the first half-cycle externally
//    or the software schedules around it.
// STRUCTURE
//  Package id_pkg: opcode localparams, alu_op_e enum (ADD,SUB,AND,OR,XOR,SLL,SRL,SRA,SLT,SLTU,LUI),
//    imm-format enum (I,S,B,U,J), idex_ctrl_t struct bundling the ex_* control bits.
//  Sub-module regfile (2R1W, bypass behind ID_WB_BYPASS_EN); decode, hazard and ID/EX reg in id_stage.
// TESTING
//  1 reset asserted mid-stream with valid ADDI in ID -> all ex_* 0 next cycle; prior x5 value retained.
//  2 ADDI x1,x0,-5 (0xFFB00093) -> ex_imm=0xFFFFFFFB, ex_rd=1, alu_src=1, reg_write=1, alu_op=ADD.
//  3 LW x3,0(x2) then ADD x4,x3,x1 -> pc_stall=1 one cycle, one bubble, ADD issues next cycle.
//  4 flush=1 together with a load-use condition -> bubble, pc_stall=0.
//  5 wb_we=1,wb_rd=7,wb_data=0xA5A5A5A5 while ID reads x7 -> 0xA5A5A5A5 with macro, old value without.
//  6 wb write to x0 with 0x1234, then read x0 -> 0; opcode 0x7F -> ex_illegal=1, reg_write=0.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode definitions for the RV32I ID stage: opcodes, ALU op encoding,
// immediate formats and the ID/EX control bundle.
package id_pkg;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_LUI    = 7'h37;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL,
    ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_LUI
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_fmt_e;

  typedef struct packed {
    logic    valid;
    alu_op_e alu_op;
    logic    alu_src;
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    logic    mem_to_reg;
    logic    branch;
    logic    jump;
    logic    illegal;
  } idex_ctrl_t;

  // funct3 selects the operation for both register and immediate ALU forms
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3);
    case (f3)
      3'd0:    return ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [31:0] imm_gen(input logic [31:0] ins, input imm_fmt_e fmt);
    case (fmt)
      IMM_I:   return {{20{ins[31]}}, ins[31:20]};
      IMM_S:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   return {ins[31:12], 12'b0};
      IMM_J:   return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 2-read / 1-write register file, x0 hardwired to zero, contents not reset.
// ID_WB_BYPASS_EN: a read of the register being written this cycle returns the write data.
module id_stage_regfile #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic [REG_ADDR_W-1:0] ra1_i,
  input  logic [REG_ADDR_W-1:0] ra2_i,
  output logic [DATA_W-1:0]     rd1_o,
  output logic [DATA_W-1:0]     rd2_o,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] wa_i,
  input  logic [DATA_W-1:0]     wd_i
);

  localparam int NREG = 2 ** REG_ADDR_W;

  logic [DATA_W-1:0] mem_q [NREG];

  always_ff @(posedge clk) begin
    if (we_i && (wa_i != '0)) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [REG_ADDR_W-1:0] a);
    if (a == '0) return '0;
`ifdef ID_WB_BYPASS_EN
    if (we_i && (wa_i == a)) return wd_i;
`endif
    return mem_q[a];
  endfunction

  assign rd1_o = read_port(ra1_i);
  assign rd2_o = read_port(ra2_i);

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: register file, instruction decode, load-use detection and ID/EX register.
// Optional write-through of write-back data into reads is enabled by ID_WB_BYPASS_EN.
module id_stage
  import id_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           instruction,
  input  logic [31:0]           next_pc,
  input  logic                  flush,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  pc_stall,
  output logic                  ex_valid,
  output logic [31:0]           ex_pc_plus4,
  output logic [DATA_W-1:0]     ex_rs1_data,
  output logic [DATA_W-1:0]     ex_rs2_data,
  output logic [31:0]           ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [3:0]            ex_alu_op,
  output logic                  ex_alu_src,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_reg_write,
  output logic                  ex_mem_to_reg,
  output logic                  ex_branch,
  output logic                  ex_jump,
  output logic                  ex_illegal
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;

  idex_ctrl_t dec_ctrl;
  imm_fmt_e   fmt;
  logic       use_rs1, use_rs2, use_rd;

  logic [REG_ADDR_W-1:0] rs1_idx, rs2_idx, rd_idx;
  logic [DATA_W-1:0]     rs1_rdata, rs2_rdata;
  logic                  load_use, kill;

  idex_ctrl_t            ctrl_d, ctrl_q;
  logic [31:0]           pc_d, pc_q, imm_d, imm_q;
  logic [DATA_W-1:0]     rs1_data_d, rs1_data_q, rs2_data_d, rs2_data_q;
  logic [REG_ADDR_W-1:0] rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;

  assign opcode = instruction[6:0];
  assign f3     = instruction[14:12];
  assign f7     = instruction[31:25];

  always_comb begin
    dec_ctrl       = '0;
    dec_ctrl.valid = (instruction != '0);
    fmt            = IMM_NONE;
    use_rs1        = 1'b0;
    use_rs2        = 1'b0;
    use_rd         = 1'b0;
    case (opcode)
      OPC_OP: begin
        {use_rs1, use_rs2, use_rd} = 3'b111;
        dec_ctrl.reg_write = 1'b1;
        if (f7 == 7'h00)                      dec_ctrl.alu_op  = alu_from_f3(f3);
        else if (f7 == 7'h20 && f3 == 3'd0)   dec_ctrl.alu_op  = ALU_SUB;
        else if (f7 == 7'h20 && f3 == 3'd5)   dec_ctrl.alu_op  = ALU_SRA;
        else                                  dec_ctrl.illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        {use_rs1, use_rd} = 2'b11;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        fmt                = IMM_I;
        dec_ctrl.alu_op    = alu_from_f3(f3);
        if (f3 == 3'd1 && f7 != 7'h00)                        dec_ctrl.illegal = 1'b1;
        if (f3 == 3'd5 && f7 == 7'h20)                        dec_ctrl.alu_op  = ALU_SRA;
        else if (f3 == 3'd5 && f7 != 7'h00)                   dec_ctrl.illegal = 1'b1;
      end
      OPC_LOAD: begin
        {use_rs1, use_rd} = 2'b11;
        dec_ctrl.alu_src    = 1'b1;
        dec_ctrl.mem_read   = 1'b1;
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        fmt                 = IMM_I;
        dec_ctrl.illegal    = (f3 != 3'd2);
      end
      OPC_STORE: begin
        {use_rs1, use_rs2} = 2'b11;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.mem_write = 1'b1;
        fmt                = IMM_S;
        dec_ctrl.illegal   = (f3 != 3'd2);
      end
      OPC_BRANCH: begin
        {use_rs1, use_rs2} = 2'b11;
        dec_ctrl.branch  = 1'b1;
        dec_ctrl.alu_op  = ALU_SUB;
        fmt              = IMM_B;
        dec_ctrl.illegal = (f3[2:1] != 2'b00);
      end
      OPC_JAL: begin
        use_rd             = 1'b1;
        dec_ctrl.jump      = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        fmt                = IMM_J;
      end
      OPC_JALR: begin
        {use_rs1, use_rd} = 2'b11;
        dec_ctrl.jump      = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        fmt                = IMM_I;
        dec_ctrl.illegal   = (f3 != 3'd0);
      end
      OPC_LUI: begin
        use_rd             = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.alu_op    = ALU_LUI;
        fmt                = IMM_U;
      end
      default: dec_ctrl.illegal = (instruction != '0);
    endcase
    // An illegal instruction travels down as a marker only: no operands, no side effects.
    if (dec_ctrl.illegal) begin
      dec_ctrl         = '0;
      dec_ctrl.valid   = 1'b1;
      dec_ctrl.illegal = 1'b1;
      fmt              = IMM_NONE;
      use_rs1          = 1'b0;
      use_rs2          = 1'b0;
      use_rd           = 1'b0;
    end
  end

  assign rs1_idx = use_rs1 ? REG_ADDR_W'(instruction[19:15]) : '0;
  assign rs2_idx = use_rs2 ? REG_ADDR_W'(instruction[24:20]) : '0;
  assign rd_idx  = use_rd  ? REG_ADDR_W'(instruction[11:7])  : '0;

  id_stage_regfile #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_regfile (
    .clk   (clk),
    .ra1_i (rs1_idx),
    .ra2_i (rs2_idx),
    .rd1_o (rs1_rdata),
    .rd2_o (rs2_rdata),
    .we_i  (wb_we),
    .wa_i  (wb_rd),
    .wd_i  (wb_data)
  );

  // Unused source fields are already zero, and rd_q is nonzero, so they never match.
  assign load_use = ctrl_q.valid && ctrl_q.mem_read && (rd_q != '0) &&
                    ((rd_q == rs1_idx) || (rd_q == rs2_idx));
  assign pc_stall = load_use && !flush && !reset;
  assign kill     = flush || load_use;

  always_comb begin
    ctrl_d     = '0;
    pc_d       = '0;
    imm_d      = '0;
    rs1_data_d = '0;
    rs2_data_d = '0;
    rs1_d      = '0;
    rs2_d      = '0;
    rd_d       = '0;
    if (!kill) begin
      ctrl_d     = dec_ctrl;
      pc_d       = dec_ctrl.valid ? next_pc : '0;
      imm_d      = imm_gen(instruction, fmt);
      rs1_data_d = rs1_rdata;
      rs2_data_d = rs2_rdata;
      rs1_d      = rs1_idx;
      rs2_d      = rs2_idx;
      rd_d       = rd_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= '0;
      pc_q       <= '0;
      imm_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      pc_q       <= pc_d;
      imm_q      <= imm_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
    end
  end

  assign ex_valid      = ctrl_q.valid;
  assign ex_pc_plus4   = pc_q;
  assign ex_rs1_data   = rs1_data_q;
  assign ex_rs2_data   = rs2_data_q;
  assign ex_imm        = imm_q;
  assign ex_rs1        = rs1_q;
  assign ex_rs2        = rs2_q;
  assign ex_rd         = rd_q;
  assign ex_alu_op     = ctrl_q.alu_op;
  assign ex_alu_src    = ctrl_q.alu_src;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_branch     = ctrl_q.branch;
  assign ex_jump       = ctrl_q.jump;
  assign ex_illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus randomized instruction stream
// compared against an ISA-level reference model with an emulated IF stall.
module tb_id_stage;
  import id_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, wb_we;
  logic [31:0] instruction, next_pc, wb_data;
  logic [4:0]  wb_rd;

  logic        pc_stall, ex_valid, ex_alu_src, ex_mem_read, ex_mem_write;
  logic        ex_reg_write, ex_mem_to_reg, ex_branch, ex_jump, ex_illegal;
  logic [31:0] ex_pc_plus4, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_alu_op;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .reset(reset), .instruction(instruction), .next_pc(next_pc), .flush(flush),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .pc_stall(pc_stall),
    .ex_valid(ex_valid), .ex_pc_plus4(ex_pc_plus4), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_illegal(ex_illegal)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  typedef struct {
    bit        valid;
    bit [31:0] pc, a, b, imm;
    bit [4:0]  rs1, rs2, rd;
    bit [3:0]  alu;
    bit        src, mr, mw, rw, m2r, br, jp, ill;
  } exp_t;

  alu_op_e   f3_alu [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
  bit [31:0] rf [32];
  exp_t      cur;
  bit        last_stall;
  logic      obs_stall;

  function automatic bit [31:0] rf_rd(input bit [4:0] a, input bit we, input bit [4:0] wa,
                                      input bit [31:0] wd);
    if (a == 0) return 0;
`ifdef ID_WB_BYPASS_EN
    if (we && wa == a) return wd;
`endif
    return rf[a];
  endfunction

  // ISA-level decode: legality, operand usage and immediates as plain arithmetic.
  function automatic exp_t ref_decode(input bit [31:0] ins, input bit [31:0] pc);
    exp_t e;
    bit [6:0] op = ins[6:0];
    bit [2:0] f3 = ins[14:12];
    bit [6:0] f7 = ins[31:25];
    bit ok = 0, u1 = 0, u2 = 0, ud = 0;
    int sgn = ins[31] ? -2048 : 0;
    int si = sgn + int'(ins[30:20]);
    int ss = sgn + int'(ins[30:25]) * 32 + int'(ins[11:7]);
    int sb = 2 * sgn + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
    int sj = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
             + int'(ins[30:21]) * 2;
    e = '{default: 0};
    case (op)
      7'h33: begin
        ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        u1 = 1; u2 = 1; ud = 1; e.rw = 1;
        e.alu = (f7 == 0) ? f3_alu[f3] : ((f3 == 0) ? ALU_SUB : ALU_SRA);
      end
      7'h13: begin
        ok = (f3 == 1) ? (f7 == 0) : ((f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1'b1);
        u1 = 1; ud = 1; e.rw = 1; e.src = 1; e.imm = si;
        e.alu = (f3 == 5 && f7 == 7'h20) ? ALU_SRA : f3_alu[f3];
      end
      7'h03: begin ok = (f3 == 2); u1 = 1; ud = 1; e.src = 1; e.mr = 1; e.rw = 1; e.m2r = 1; e.imm = si; end
      7'h23: begin ok = (f3 == 2); u1 = 1; u2 = 1; e.src = 1; e.mw = 1; e.imm = ss; end
      7'h63: begin ok = (f3 <= 1); u1 = 1; u2 = 1; e.br = 1; e.alu = ALU_SUB; e.imm = sb; end
      7'h6F: begin ok = 1; ud = 1; e.jp = 1; e.rw = 1; e.imm = sj; end
      7'h67: begin ok = (f3 == 0); u1 = 1; ud = 1; e.jp = 1; e.rw = 1; e.src = 1; e.imm = si; end
      7'h37: begin ok = 1; ud = 1; e.rw = 1; e.src = 1; e.alu = ALU_LUI; e.imm = ins & 32'hFFFF_F000; end
      default: ok = 0;
    endcase
    if (ins == 0) begin
      e = '{default: 0};
      return e;
    end
    if (!ok) begin
      e = '{default: 0};
      e.valid = 1; e.ill = 1; e.pc = pc;
      return e;
    end
    e.valid = 1;
    e.pc    = pc;
    e.rs1   = u1 ? ins[19:15] : 5'd0;
    e.rs2   = u2 ? ins[24:20] : 5'd0;
    e.rd    = ud ? ins[11:7]  : 5'd0;
    return e;
  endfunction

  task automatic compare(input exp_t e);
    check_eq("ex_valid",      ex_valid,      e.valid);
    check_eq("ex_pc_plus4",   ex_pc_plus4,   e.pc);
    check_eq("ex_rs1_data",   ex_rs1_data,   e.a);
    check_eq("ex_rs2_data",   ex_rs2_data,   e.b);
    check_eq("ex_imm",        ex_imm,        e.imm);
    check_eq("ex_rs1",        ex_rs1,        e.rs1);
    check_eq("ex_rs2",        ex_rs2,        e.rs2);
    check_eq("ex_rd",         ex_rd,         e.rd);
    check_eq("ex_alu_op",     ex_alu_op,     e.alu);
    check_eq("ex_alu_src",    ex_alu_src,    e.src);
    check_eq("ex_mem_read",   ex_mem_read,   e.mr);
    check_eq("ex_mem_write",  ex_mem_write,  e.mw);
    check_eq("ex_reg_write",  ex_reg_write,  e.rw);
    check_eq("ex_mem_to_reg", ex_mem_to_reg, e.m2r);
    check_eq("ex_branch",     ex_branch,     e.br);
    check_eq("ex_jump",       ex_jump,       e.jp);
    check_eq("ex_illegal",    ex_illegal,    e.ill);
  endtask

  // One clock: drive inputs, check pc_stall, predict the ID/EX content, clock, compare.
  task automatic step(input bit [31:0] ins, input bit [31:0] pc, input bit fl, input bit rst,
                      input bit we, input bit [4:0] wa, input bit [31:0] wd);
    exp_t dec, nxt;
    bit   stall_exp;
    instruction = ins; next_pc = pc; flush = fl; reset = rst;
    wb_we = we; wb_rd = wa; wb_data = wd;
    #1;
    dec = ref_decode(ins, pc);
    dec.a = rf_rd(dec.rs1, we, wa, wd);
    dec.b = rf_rd(dec.rs2, we, wa, wd);
    stall_exp = !rst && !fl && cur.valid && cur.mr && (cur.rd != 0) &&
                (cur.rd == dec.rs1 || cur.rd == dec.rs2);
    obs_stall = pc_stall;
    check_eq("pc_stall", pc_stall, stall_exp);
    last_stall = stall_exp;
    if (rst || fl || stall_exp) nxt = '{default: 0};
    else                        nxt = dec;
    if (we && wa != 0) rf[wa] = wd;
    @(posedge clk);
    #1;
    cur = nxt;
    compare(cur);
  endtask

  function automatic bit [31:0] rand_ins();
    bit [4:0]  r1 = 5'($urandom_range(0, 7));
    bit [4:0]  r2 = 5'($urandom_range(0, 7));
    bit [4:0]  rd = 5'($urandom_range(0, 7));
    bit [2:0]  f3 = 3'($urandom);
    bit [31:0] hi = $urandom;
    case ($urandom_range(0, 11))
      0:       return {(($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00), r2, r1, f3, rd, 7'h33};
      1:       return {hi[31:20], r1, f3, rd, 7'h13};
      2, 9:    return {hi[31:20], r1, 3'd2, rd, 7'h03};
      3:       return {hi[31:25], r2, r1, 3'd2, hi[11:7], 7'h23};
      4:       return {hi[31:25], r2, r1, 2'b00, hi[12], hi[11:7], 7'h63};
      5:       return {hi[31:12], rd, 7'h6F};
      6:       return {hi[31:20], r1, 3'd0, rd, 7'h67};
      7:       return {hi[31:12], rd, 7'h37};
      8:       return 32'h0;
      10:      return hi;
      default: return {hi[31:7], 7'h7F};
    endcase
  endfunction

  initial begin
    bit [31:0] held_ins;
    bit [31:0] pc_ctr;
    cur = '{default: 0};
    last_stall = 0;
    foreach (rf[i]) rf[i] = 0;

    step(32'h0, 32'h0, 0, 1, 0, 0, 0);
    step(32'h0, 32'h0, 0, 1, 0, 0, 0);
    for (int r = 1; r < 32; r++) step(32'h0, 32'h0, 0, 0, 1, 5'(r), $urandom);

    // Reset mid-stream with ADDI in ID; x5 must survive
    step(32'h0, 32'h0, 0, 0, 1, 5'd5, 32'h0000_0055);
    step(32'hFFB0_0093, 32'h104, 0, 1, 0, 0, 0);
    check_eq("t1_valid_after_reset", ex_valid, 1'b0);
    check_eq("t1_rw_after_reset", ex_reg_write, 1'b0);
    step(32'h0002_8333, 32'h108, 0, 0, 0, 0, 0);
    check_eq("t1_x5_retained", ex_rs1_data, 32'h0000_0055);

    // ADDI x1,x0,-5
    step(32'hFFB0_0093, 32'h10C, 0, 0, 0, 0, 0);
    check_eq("t2_imm", ex_imm, 32'hFFFF_FFFB);
    check_eq("t2_rd", ex_rd, 5'd1);
    check_eq("t2_alu_src", ex_alu_src, 1'b1);
    check_eq("t2_reg_write", ex_reg_write, 1'b1);
    check_eq("t2_alu_op", ex_alu_op, 4'(ALU_ADD));
    check_eq("t2_pc", ex_pc_plus4, 32'h10C);

    // LW x3,0(x2) then ADD x4,x3,x1: one stall, one bubble
    step(32'h0001_2183, 32'h110, 0, 0, 0, 0, 0);
    step(32'h0011_8233, 32'h114, 0, 0, 0, 0, 0);
    check_eq("t3_stall", obs_stall, 1'b1);
    check_eq("t3_bubble", ex_valid, 1'b0);
    step(32'h0011_8233, 32'h114, 0, 0, 0, 0, 0);
    check_eq("t3_no_stall", obs_stall, 1'b0);
    check_eq("t3_add_rd", ex_rd, 5'd4);
    check_eq("t3_add_valid", ex_valid, 1'b1);

    // Flush on top of a load-use
    step(32'h0001_2183, 32'h118, 0, 0, 0, 0, 0);
    step(32'h0011_8233, 32'h11C, 1, 0, 0, 0, 0);
    check_eq("t4_stall_masked", obs_stall, 1'b0);
    check_eq("t4_bubble", ex_valid, 1'b0);

    // Write-back into the register being read
    step(32'h0, 32'h0, 0, 0, 1, 5'd7, 32'h0000_0011);
    step(32'h0003_8433, 32'h120, 0, 0, 1, 5'd7, 32'hA5A5_A5A5);
`ifdef ID_WB_BYPASS_EN
    check_eq("t5_bypass", ex_rs1_data, 32'hA5A5_A5A5);
`else
    check_eq("t5_old_value", ex_rs1_data, 32'h0000_0011);
`endif

    // x0 write ignored; illegal opcode
    step(32'h0, 32'h0, 0, 0, 1, 5'd0, 32'h0000_1234);
    step(32'h0000_04B3, 32'h124, 0, 0, 0, 0, 0);
    check_eq("t6_x0_read", ex_rs1_data, 32'h0);
    step(32'h0000_007F, 32'h128, 0, 0, 0, 0, 0);
    check_eq("t6_illegal", ex_illegal, 1'b1);
    check_eq("t6_illegal_rw", ex_reg_write, 1'b0);
    check_eq("t6_illegal_valid", ex_valid, 1'b1);

    // Random stream; IF is emulated by holding the instruction while stalled
    held_ins = 0;
    pc_ctr   = 32'h1000;
    for (int i = 0; i < 600; i++) begin
      bit        fl, rst, we;
      bit [4:0]  wa;
      bit [31:0] wd;
      if (!last_stall) begin
        held_ins = rand_ins();
        pc_ctr   = pc_ctr + 4;
      end
      rst = ($urandom_range(0, 49) == 0);
      fl  = ($urandom_range(0, 7) == 0);
      we  = !rst && ($urandom_range(0, 1) == 1);
      wa  = 5'($urandom_range(0, 7));
      wd  = $urandom;
      step(held_ins, pc_ctr, fl, rst, we, wa, wd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
